// File: rtl/hd_pkg.sv
// Shared types and constants for the code-to-word mask decoder.
package hd_pkg;

  typedef enum logic {
    ONEHOT  = 1'b0,
    LOWMASK = 1'b1
  } hd_dec_mode_e;

  localparam int HD_WORD_W   = 32;
  localparam int HD_CODE_MAX = 32;

endpackage

// File: rtl/hd_mask_decoder_if.sv
// Stream bundle for hd_mask_decoder: code input side, word output side and the delivered-word count.
interface hd_mask_decoder_if #(
  parameter int CODE_W = 6,
  parameter int CNT_W  = 16
);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both 1; a producer holding valid keeps its payload stable
  // until that transfer and never drops valid without one.
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic              out_err;
  logic [CNT_W-1:0]  dec_count;

  modport master (
    output in_valid, in_code, in_mode, out_ready,
    input  in_ready, out_valid, out_word, out_err, dec_count
  );

  modport slave (
    input  in_valid, in_code, in_mode, out_ready,
    output in_ready, out_valid, out_word, out_err, dec_count
  );

endinterface

// File: rtl/hd_mask_expand.sv
// Combinational expansion of a bit-position code into a one-hot or low-bit mask word.
// Range flagging is built only with HD_MASK_DEC_RANGE_CHECK_EN defined.
module hd_mask_expand
  import hd_pkg::*;
#(
  parameter int CODE_W = 6
) (
  input  logic [CODE_W-1:0]    code,
  input  hd_dec_mode_e         mode,
  output logic [HD_WORD_W-1:0] word,
  output logic                 err
);

  logic [5:0]  shamt;
  logic [32:0] pow2;
  logic        in_range;

  always_comb begin
    shamt = 6'(code);
    pow2  = 33'd1 << shamt;
`ifdef HD_MASK_DEC_RANGE_CHECK_EN
    in_range = (32'(code) <= 32'(HD_CODE_MAX));
    err      = !in_range;
`else
    // Only the low six bits matter; 33..63 fall outside the word and give 0.
    in_range = (shamt <= 6'(HD_CODE_MAX));
    err      = 1'b0;
`endif
    word = '0;
    if (in_range) begin
      if (mode == LOWMASK) word = 32'(pow2 - 33'd1);
      else                 word = pow2[31:0];
    end
  end

endmodule

// File: rtl/hd_mask_decoder.sv
// Two-stage valid/ready pipeline re-expanding bit-position codes into 32-bit words, with a wrapping delivered-word count.
// HD_MASK_DEC_RANGE_CHECK_EN enables flagging of codes above 32 (see hd_mask_expand).
module hd_mask_decoder
  import hd_pkg::*;
#(
  parameter int CODE_W = 6,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  hd_mask_decoder_if.slave bus
);

  logic                 s1_valid;
  logic [CODE_W-1:0]    s1_code;
  hd_dec_mode_e         s1_mode;
  logic                 s2_valid;
  logic [HD_WORD_W-1:0] s2_word;
  logic                 s2_err;
  logic [CNT_W-1:0]     cnt;

  logic                 s1_adv;
  logic                 s2_adv;
  logic [HD_WORD_W-1:0] exp_word;
  logic                 exp_err;

  // A stage may load when it is empty or its contents move on this edge,
  // so out_ready reaches in_ready combinationally.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_word  = s2_word;
  assign bus.out_err   = s2_err;
  assign bus.dec_count = cnt;

  hd_mask_expand #(
    .CODE_W(CODE_W)
  ) u_expand (
    .code (s1_code),
    .mode (s1_mode),
    .word (exp_word),
    .err  (exp_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_mode  <= ONEHOT;
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_err   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_code <= bus.in_code;
          s1_mode <= hd_dec_mode_e'(bus.in_mode);
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_word <= exp_word;
          s2_err  <= exp_err;
        end
      end
      if (s2_valid && bus.out_ready) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
